// File: rtl/srpt_grant_pacer.sv
// Grant pacer: holds one popped grant and releases it to egress once the
// byte-token bucket, the minimum inter-grant gap and egress space all allow.
module srpt_grant_pacer #(
    parameter int unsigned DATA_W     = 95,
    parameter int unsigned BUCKET_W   = 16,
    parameter int unsigned GRANT_COST = 64,
    parameter int unsigned MIN_GAP    = 4
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_ce,
    input  logic                pace_en_i,
    input  logic [7:0]          refill_i,
    input  logic [BUCKET_W-1:0] bucket_max_i,
    input  logic                grant_pkt_empty_i,
    output logic                grant_pkt_read_en_o,
    input  logic [DATA_W-1:0]   grant_pkt_data_i,
    input  logic                grant_out_full_i,
    output logic                grant_out_write_en_o,
    output logic [DATA_W-1:0]   grant_out_data_o,
    output logic [31:0]         grants_sent_o,
    output logic [31:0]         stall_cycles_o
);

    localparam int unsigned TOK_W = BUCKET_W + 1;
    localparam int unsigned GAP_W = $clog2(MIN_GAP);
    localparam logic [TOK_W-1:0] COST       = TOK_W'(GRANT_COST);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [BUCKET_W-1:0] tokens_q, tokens_d;
    logic [GAP_W-1:0]    gap_q;
    logic [DATA_W-1:0]   data_q;
    logic [31:0]         sent_q;
    logic [31:0]         stall_q;

    logic                pace_ok;
    logic                send;
    logic [TOK_W-1:0]    tok_ext;
    logic [TOK_W-1:0]    after_cost;
    logic [TOK_W-1:0]    refilled;
    logic [TOK_W-1:0]    max_ext;

    assign tok_ext = {1'b0, tokens_q};
    assign max_ext = {1'b0, bucket_max_i};
    assign pace_ok = !pace_en_i || ((tok_ext >= COST) && (gap_q == '0));

    // Next state and pop/push strobes; reset suppresses both strobes.
    always_comb begin
        state_d             = state_q;
        grant_pkt_read_en_o = 1'b0;
        send                = 1'b0;
        case (state_q)
            IDLE: begin
                if (ap_ce && !ap_rst && !grant_pkt_empty_i) begin
                    grant_pkt_read_en_o = 1'b1;
                    state_d             = HOLD;
                end
            end
            HOLD: begin
                if (ap_ce && !ap_rst && !grant_out_full_i && pace_ok) begin
                    send    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_out_write_en_o = send;

    // Bucket update; cost clamps at zero when pacing is off.
    always_comb begin
        after_cost = tok_ext;
        if (send) begin
            after_cost = (tok_ext >= COST) ? (tok_ext - COST) : '0;
        end
        refilled = after_cost + TOK_W'(refill_i);
        tokens_d = (refilled > max_ext) ? bucket_max_i : refilled[BUCKET_W-1:0];
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= IDLE;
            tokens_q <= '0;
            gap_q    <= '0;
            data_q   <= '0;
            sent_q   <= '0;
            stall_q  <= '0;
        end else if (ap_ce) begin
            state_q  <= state_d;
            tokens_q <= tokens_d;
            if (send) begin
                gap_q <= GAP_RELOAD;
            end else if (gap_q != '0) begin
                gap_q <= gap_q - GAP_W'(1);
            end
            if (grant_pkt_read_en_o) begin
                data_q <= grant_pkt_data_i;
            end
            if (send) begin
                sent_q <= sent_q + 32'd1;
            end
            if ((state_q == HOLD) && !send && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign grant_out_data_o = data_q;
    assign grants_sent_o    = sent_q;
    assign stall_cycles_o   = stall_q;

endmodule

// File: tb/tb_srpt_grant_pacer.sv
// Bench for srpt_grant_pacer: directed scenarios plus a randomized phase, all
// checked each cycle against a behavioural model of the held grant and bucket.
module tb_srpt_grant_pacer;

    localparam int unsigned DATA_W   = 95;
    localparam int unsigned BUCKET_W = 16;
    localparam int          COST     = 64;
    localparam int          GAP      = 4;

    logic                ap_clk = 1'b0;
    logic                ap_rst;
    logic                ap_ce;
    logic                pace_en_i;
    logic [7:0]          refill_i;
    logic [BUCKET_W-1:0] bucket_max_i;
    logic                grant_pkt_empty_i;
    logic                grant_pkt_read_en_o;
    logic [DATA_W-1:0]   grant_pkt_data_i;
    logic                grant_out_full_i;
    logic                grant_out_write_en_o;
    logic [DATA_W-1:0]   grant_out_data_o;
    logic [31:0]         grants_sent_o;
    logic [31:0]         stall_cycles_o;

    srpt_grant_pacer #(
        .DATA_W(DATA_W), .BUCKET_W(BUCKET_W), .GRANT_COST(COST), .MIN_GAP(GAP)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce), .pace_en_i(pace_en_i),
        .refill_i(refill_i), .bucket_max_i(bucket_max_i),
        .grant_pkt_empty_i(grant_pkt_empty_i), .grant_pkt_read_en_o(grant_pkt_read_en_o),
        .grant_pkt_data_i(grant_pkt_data_i), .grant_out_full_i(grant_out_full_i),
        .grant_out_write_en_o(grant_out_write_en_o), .grant_out_data_o(grant_out_data_o),
        .grants_sent_o(grants_sent_o), .stall_cycles_o(stall_cycles_o)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: one optional held grant, integer bucket and gap.
    logic [DATA_W-1:0] upq[$];
    bit                m_held;
    logic [DATA_W-1:0] m_data;
    int                m_tok;
    int                m_gap;
    logic [31:0]       m_sent;
    logic [31:0]       m_stall;
    logic              seen_wr;
    logic [DATA_W-1:0] seen_data;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_data = '0; m_tok = 0; m_gap = 0; m_sent = '0; m_stall = '0;
    endtask

    // One clock cycle: drive FIFO head, check strobes, advance model, check registers.
    task automatic tick();
        logic exp_rd, exp_wr;
        int   t;
        grant_pkt_empty_i = (upq.size() == 0);
        grant_pkt_data_i  = (upq.size() != 0) ? upq[0] : '0;
        exp_rd = 1'b0;
        exp_wr = 1'b0;
        if (!ap_rst && ap_ce) begin
            if (!m_held) exp_rd = (upq.size() != 0);
            else exp_wr = !grant_out_full_i && (!pace_en_i || (m_tok >= COST && m_gap == 0));
        end
        #3;
        seen_wr   = grant_out_write_en_o;
        seen_data = grant_out_data_o;
        check("read_en", 128'(grant_pkt_read_en_o), 128'(exp_rd));
        check("write_en", 128'(grant_out_write_en_o), 128'(exp_wr));
        @(posedge ap_clk);
        if (ap_rst) begin
            model_reset();
        end else if (ap_ce) begin
            t = m_tok - (exp_wr ? COST : 0);
            if (t < 0) t = 0;
            t = t + int'(refill_i);
            if (t > int'(bucket_max_i)) t = int'(bucket_max_i);
            m_tok = t;
            if (exp_wr) m_gap = GAP - 1;
            else if (m_gap > 0) m_gap--;
            if (m_held && !exp_wr && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (exp_wr) begin m_held = 0; m_sent++; end
            if (exp_rd) begin m_held = 1; m_data = upq.pop_front(); end
        end
        #1;
        check("data", 128'(grant_out_data_o), 128'(m_data));
        check("grants_sent", 128'(grants_sent_o), 128'(m_sent));
        check("stall_cycles", 128'(stall_cycles_o), 128'(m_stall));
    endtask

    // Cycles up to and including the next write, bounded.
    task automatic wait_wr(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!seen_wr && n < limit);
        check("write_seen", 128'(seen_wr), 128'(1'b1));
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        tick();
        tick();
        ap_rst = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        return DATA_W'({$urandom(), $urandom(), $urandom()});
    endfunction

    initial begin
        int   n;
        logic wr_any;
        ap_rst = 1'b1; ap_ce = 1'b1; pace_en_i = 1'b0; refill_i = '0;
        bucket_max_i = '0; grant_out_full_i = 1'b0;
        grant_pkt_empty_i = 1'b1; grant_pkt_data_i = '0;
        model_reset();
        @(posedge ap_clk);
        #1;
        do_reset();
        check("rst_data", 128'(grant_out_data_o), 128'(0));
        check("rst_sent", 128'(grants_sent_o), 128'(0));
        check("rst_stall", 128'(stall_cycles_o), 128'(0));

        // Pass-through: pacing off, one grant per two cycles, data in order.
        for (int k = 1; k <= 5; k++) upq.push_back(DATA_W'(k));
        for (int k = 1; k <= 5; k++) begin
            wait_wr(10, n);
            check("pt_spacing", 128'(n), 128'(2));
            check("pt_data", 128'(seen_data), 128'(k));
        end
        check("pt_sent", 128'(grants_sent_o), 128'(5));
        check("pt_stall", 128'(stall_cycles_o), 128'(0));

        // Token limit: refill 8, cost 64 -> first write cycle 8, then every 8.
        do_reset();
        pace_en_i = 1'b1; refill_i = 8'd8; bucket_max_i = 16'd256;
        for (int k = 0; k < 4; k++) upq.push_back(rand_data());
        wait_wr(40, n);
        check("tok_first_cycle", 128'(n - 1), 128'(8));
        for (int k = 0; k < 3; k++) begin
            wait_wr(40, n);
            check("tok_spacing", 128'(n), 128'(8));
        end

        // Gap limit: plenty of tokens, writes MIN_GAP apart, two stalls each.
        do_reset();
        refill_i = 8'd255; bucket_max_i = 16'd1000;
        for (int k = 0; k < 4; k++) upq.push_back(rand_data());
        wait_wr(10, n);
        check("gap_first", 128'(n), 128'(2));
        for (int k = 0; k < 3; k++) begin
            wait_wr(20, n);
            check("gap_spacing", 128'(n), 128'(4));
        end
        check("gap_stall", 128'(stall_cycles_o), 128'(6));

        // Back-pressure: egress full for 10 held cycles, release on deassert.
        grant_out_full_i = 1'b1;
        upq.push_back(DATA_W'(32'hABC));
        tick();
        wr_any = 1'b0;
        repeat (10) begin tick(); wr_any |= seen_wr; end
        check("bp_no_write", 128'(wr_any), 128'(0));
        check("bp_data_held", 128'(grant_out_data_o), 128'(32'hABC));
        check("bp_stall", 128'(stall_cycles_o), 128'(16));
        grant_out_full_i = 1'b0;
        tick();
        check("bp_release", 128'(seen_wr), 128'(1));

        // Dead configuration: ceiling below cost, stuck until pacing is dropped.
        do_reset();
        refill_i = 8'd8; bucket_max_i = 16'd32;
        upq.push_back(rand_data());
        wr_any = 1'b0;
        repeat (20) begin tick(); wr_any |= seen_wr; end
        check("dead_no_write", 128'(wr_any), 128'(0));
        check("dead_stall", 128'(stall_cycles_o), 128'(19));
        pace_en_i = 1'b0;
        tick();
        check("dead_release", 128'(seen_wr), 128'(1));

        // Reset while holding drops the grant.
        pace_en_i = 1'b1;
        upq.push_back(DATA_W'(32'h55));
        tick();
        tick();
        check("hold_data", 128'(grant_out_data_o), 128'(32'h55));
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        check("rst_hold_data", 128'(grant_out_data_o), 128'(0));
        check("rst_hold_sent", 128'(grants_sent_o), 128'(0));
        check("rst_hold_stall", 128'(stall_cycles_o), 128'(0));
        wr_any = 1'b0;
        repeat (4) begin tick(); wr_any |= seen_wr; end
        check("rst_dropped", 128'(wr_any), 128'(0));

        // Clock enable low for 5 cycles mid-gap stretches the interval by 5.
        do_reset();
        refill_i = 8'd255; bucket_max_i = 16'd1000;
        upq.push_back(rand_data());
        upq.push_back(rand_data());
        wait_wr(10, n);
        tick();
        ap_ce = 1'b0;
        repeat (5) tick();
        check("ce_sent_frozen", 128'(grants_sent_o), 128'(1));
        check("ce_stall_frozen", 128'(stall_cycles_o), 128'(0));
        ap_ce = 1'b1;
        wait_wr(20, n);
        check("ce_delay", 128'(n + 6), 128'(GAP + 5));

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            ap_rst           = ($urandom_range(0, 199) == 0);
            ap_ce            = ($urandom_range(0, 9) != 0);
            grant_out_full_i = ($urandom_range(0, 3) == 0);
            refill_i         = 8'($urandom_range(0, 40));
            if ($urandom_range(0, 49) == 0) pace_en_i = ~pace_en_i;
            if ($urandom_range(0, 99) == 0) bucket_max_i = 16'($urandom_range(0, 600));
            if (upq.size() < 8 && $urandom_range(0, 2) == 0) upq.push_back(rand_data());
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/srpt_grant_pacer.md
# srpt_grant_pacer

Rate-limits the grant packets produced by `srpt_grant_pkts` before they reach the egress packet FIFO. It pops one grant at a time from the grant queue's FWFT output FIFO and holds it in a single-entry register. The grant is released only when three conditions hold: a byte-token bucket has enough credit, a minimum inter-grant gap has elapsed, and egress is not full. This bounds the rate at which the receiver re-opens sender windows (overcommit control). Counters expose throughput and back-pressure for debug.

## Interface
Parameters:
- `DATA_W`, 95: grant packet width; payload is opaque and passes through unmodified.
- `BUCKET_W`, 16: token counter width (bytes).
- `GRANT_COST`, 64: tokens consumed per grant sent; must satisfy `0 < GRANT_COST < 2^BUCKET_W`.
- `MIN_GAP`, 4: minimum cycles between consecutive `grant_out_write_en_o` pulses; must be ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- `ap_clk`  in  1  clock.
- `ap_rst`  in  1  synchronous active-high reset.
- `ap_ce`  in  1  clock enable; when 0, all state and counters freeze and both strobes are 0.
- `pace_en_i`  in  1  when 1, the token and gap checks apply; when 0, a grant is sent whenever egress is not full.
- `refill_i`  in  8  tokens added per enabled cycle.
- `bucket_max_i`  in  BUCKET_W  bucket ceiling.
- `grant_pkt_empty_i`  in  1  upstream FIFO empty.
- `grant_pkt_read_en_o`  out  1  pop strobe; data is valid while empty=0 (FWFT).
- `grant_pkt_data_i`  in  DATA_W  upstream head word.
- `grant_out_full_i`  in  1  egress FIFO full.
- `grant_out_write_en_o`  out  1  push strobe.
- `grant_out_data_o`  out  DATA_W  registered held grant.
- `grants_sent_o`  out  32  grants written; wraps mod 2^32.
- `stall_cycles_o`  out  32  cycles in HOLD without a write; saturates at 0xFFFFFFFF.

## Operation
- FSM states are IDLE and HOLD. Reset values: state=IDLE, tokens=0, gap_cnt=0, `grant_out_data_o`=0, both counters 0, both strobes 0.
- **IDLE.** If `ap_ce` & !`grant_pkt_empty_i`:
  - `grant_pkt_read_en_o`=1 (combinational, same cycle).
  - `grant_pkt_data_i` is captured into `grant_out_data_o`.
  - Next state is HOLD.
  - Otherwise the FSM stays in IDLE and `read_en`=0.
- **HOLD.** Define `send = ap_ce & !grant_out_full_i & (!pace_en_i | (tokens ≥ GRANT_COST & gap_cnt == 0))`.
  - `grant_out_write_en_o = send` (combinational).
  - On `send`: gap_cnt ← MIN_GAP−1, `grants_sent_o`++, next state is IDLE.
  - Otherwise the FSM stays in HOLD and `stall_cycles_o`++ (saturating).
- **Tokens**, updated on every `ap_ce` cycle in any state:
  - `tokens ← min(tokens − (send ? GRANT_COST : 0) + refill_i, bucket_max_i)`.
  - Compute in BUCKET_W+1 bits; the subtraction never underflows because `send` under pacing implies tokens ≥ GRANT_COST.
  - With `pace_en_i`=0, cost is still deducted, but clamped at 0.
- **gap_cnt** decrements by 1 per `ap_ce` cycle while nonzero. It is reloaded on `send`; the reload takes priority over the decrement.
- **Lowering `bucket_max_i`** below the current token count clamps tokens on the next enabled cycle.
- **Dead configuration.** If `bucket_max_i` < GRANT_COST with `pace_en_i`=1, the held grant is never sent. The FSM stays in HOLD and `stall_cycles_o` counts. This is a configuration error and is not detected.
- **Reset mid-operation.** The held grant is discarded (it was already popped). All state returns to reset values on the next edge.
- **Toggling `pace_en_i`** takes effect in the same cycle.

## Timing
- Latency from a non-empty head to the earliest write is 1 cycle: pop at cycle t, write at t+1.
- Maximum throughput is one grant per 2 cycles (IDLE→HOLD→IDLE).
- With pacing, consecutive writes are ≥ max(2, MIN_GAP) cycles apart, since a write at t allows the next write no earlier than t+MIN_GAP.
- Steady-state paced rate is one grant per max(MIN_GAP, ⌈GRANT_COST/refill_i⌉) cycles.
- `grant_out_data_o` is stable from the cycle after the pop until the write cycle inclusive.
- `grant_pkt_read_en_o` is never asserted when `grant_pkt_empty_i`=1.
- `grant_out_write_en_o` is never asserted when `grant_out_full_i`=1.
- `ap_ce`=0 stretches every interval by the number of disabled cycles.

## Test plan
- **Pass-through.** Stimulus: `pace_en_i`=0, egress never full, 5 queued grants with data 0x1..0x5. Required: writes on cycles 1,3,5,7,9 after the first pop; data 0x1..0x5 in order; `grants_sent_o`=5; `stall_cycles_o`=0.
- **Token limit.** Stimulus: `pace_en_i`=1, `refill_i`=8, `bucket_max_i`=256, GRANT_COST=64, MIN_GAP=4, 4 grants queued from reset. Required: first write when tokens reach 64 (cycle 8 after reset); subsequent writes exactly 8 cycles apart.
- **Gap limit.** Stimulus: `refill_i`=255, `bucket_max_i`=1000, MIN_GAP=4, 4 grants queued. Required: writes exactly 4 cycles apart; `stall_cycles_o` increments by 2 per grant.
- **Back-pressure.** Stimulus: `grant_out_full_i`=1 for 10 cycles while a grant is held. Required: no write; data held; `stall_cycles_o` +10; write in the cycle full deasserts (if tokens and gap allow).
- **Bucket clamp and dead config.** Stimulus: `bucket_max_i`=32 with `pace_en_i`=1. Required: tokens saturate at 32; grant stuck in HOLD. Then set `pace_en_i`=0. Required: write in the same cycle.
- **Reset and clock enable.** Stimulus: assert `ap_rst` while in HOLD; separately hold `ap_ce`=0 for 5 cycles mid-gap. Required: after reset, all outputs 0 and the held grant is dropped; during `ap_ce`=0, tokens, gap and counters are frozen and the write is delayed by exactly 5 cycles.
